sr_latch_sequencer: RTL and testbench
=====================================

SR_LATCH_SEQUENCER -- requirements
Module: sr_latch_sequencer

Interface
REQ-001 The block SHALL have parameter PULSE_W, default 2: cycles s or r is held high per command; legal range 1..15.
REQ-002 The block SHALL have parameter GAP_W, default 1: cycles s=r=0 after each pulse, before the q check; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, 2 bits: per-requester command request, level, held until granted.
REQ-006 The block SHALL have port op, input, 2 bits: per-requester operation, 1=set, 0=clear; valid while req is high.
REQ-007 The block SHALL have port q_fb, input, 1 bit: q output of the external SR latch.
REQ-008 The block SHALL have port gnt, output, 2 bits: one-hot grant, a single-cycle pulse on acceptance.
REQ-009 The block SHALL have port s, output, 1 bit: latch set drive, registered.
REQ-010 The block SHALL have port r, output, 1 bit: latch reset drive, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: single-cycle pulse at the end of each command.
REQ-013 The block SHALL have port err, output, 1 bit: result of the last check, 1 = q_fb mismatched the expected value.

Function
REQ-014 The FSM SHALL have states IDLE, PULSE, GAP and CHECK, with transitions IDLE->PULSE->GAP->CHECK->IDLE only.
REQ-015 In IDLE, at a rising edge where any req bit is high, the block SHALL latch the winner index and its op, pulse gnt for that winner for the following cycle, and enter PULSE.
REQ-016 Arbitration SHALL be round-robin: with a single request, that request wins; with both requesting, the requester not granted most recently wins; after reset, requester 0 wins a tie.
REQ-017 The loser of arbitration SHALL keep its request pending, and be granted at the next IDLE edge if req is still high.
REQ-018 A req deasserted before it is granted SHALL be dropped without any side effect.
REQ-019 In PULSE, s SHALL equal the latched op and r its inverse, for exactly PULSE_W cycles, timed by a down-counter reloaded on entry.
REQ-020 In GAP, s=r=0 SHALL hold for exactly GAP_W cycles.
REQ-021 CHECK SHALL last exactly 1 cycle with s=r=0; at the edge leaving CHECK, err SHALL be loaded with (q_fb != latched op) and done SHALL pulse for the following cycle.
REQ-022 The command latency from the grant edge to the done pulse SHALL be PULSE_W+GAP_W+1 cycles; a back-to-back request SHALL be granted at the first edge in IDLE, i.e. the edge after done goes high.
REQ-023 s and r SHALL never be high in the same cycle, under any input, including op changing mid-command.
REQ-024 Changes on req or op while busy SHALL NOT affect the command in flight.
REQ-025 err SHALL hold its value between checks, and SHALL be overwritten only by the next CHECK.
REQ-026 gnt SHALL be zero or one-hot in every cycle; done and gnt SHALL never be high in the same cycle.
REQ-027 The counter SHALL be 4 bits wide, and SHALL not wrap: it counts down to 1, then the FSM advances.

Reset
REQ-028 With rst_n low, the block SHALL immediately (asynchronously) force state=IDLE, s=0, r=0, gnt=0, busy=0, done=0, err=0, counter=0, and round-robin pointer = requester 0 preferred.
REQ-029 Reset asserted mid-PULSE SHALL drop s/r to 0 without waiting for a clock edge, and the in-flight command SHALL be discarded with no done.
REQ-030 After rst_n deasserts, the first rising edge SHALL be treated as a normal IDLE edge.

Verification
REQ-031 Single set, defaults: req=01, op=01, q_fb follows s -> gnt=01 for 1 cycle; s=1 for 2 cycles; 1 cycle of s=r=0 (GAP); 1 cycle of CHECK; done pulse; err=0; busy high for 4 cycles.
REQ-032 Tie: req=11 held, op=10 -> first gnt=01 with a clear (r=1, 2 cycles); second gnt=10 with a set (s=1); gnt alternates thereafter; s&r==0 checked every cycle.
REQ-033 Stuck latch: q_fb tied 0, set command -> err=1 after CHECK; a following clear command -> err=0.
REQ-034 Mid-command reset: assert rst_n=0 during the 2nd PULSE cycle -> s=0 before the next edge; no done; all outputs at reset values; a req after release is granted normally.
REQ-035 Parameter sweep PULSE_W=1 / GAP_W=3 and PULSE_W=15 / GAP_W=15 -> the s/r width and grant-to-done latency (PULSE_W+GAP_W+1) match exactly, with no counter wrap.
REQ-036 Dropped request: req=10 pulsed for 1 cycle while busy -> no gnt=10 is ever issued.

Source files
------------

// File: rtl/sr_latch_sequencer.sv
// -----------------------------------------------------------------------------
// sr_latch_sequencer
//
// Purpose:
//   Arbitrates between two requesters and drives an external SR latch
//   through its set/reset inputs. Each accepted command is a fixed
//   sequence: PULSE_W cycles of s (set) or r (clear), then GAP_W idle
//   cycles, then one CHECK cycle. At the end of CHECK the latch output
//   q_fb is compared with the commanded value and the result is
//   registered on err.
//
// Parameters:
//   PULSE_W  cycles s or r is held high per command (1..15)
//   GAP_W    cycles of s=r=0 after the pulse, before the check (1..15)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [1:0] per-requester command request (level, held until gnt)
//   op     in   [1:0] per-requester operation, 1=set 0=clear
//   q_fb   in   q output of the external SR latch
//   gnt    out  [1:0] one-hot grant, single-cycle pulse on acceptance
//   s      out  latch set drive (registered)
//   r      out  latch reset drive (registered)
//   busy   out  high whenever the sequencer is not idle
//   done   out  single-cycle pulse at the end of each command
//   err    out  1 = q_fb did not match the commanded value at the last check
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sr_latch_sequencer #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] op,
  input  logic       q_fb,
  output logic [1:0] gnt,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic [3:0] PULSE_LD = 4'(PULSE_W);
  localparam logic [3:0] GAP_LD   = 4'(GAP_W);

  state_t     state;
  logic [3:0] cnt;
  logic       op_l;      // operation of the command in flight
  logic       prio;      // requester that wins a tie (not granted most recently)

  logic       win_nxt;
  logic       op_nxt;

  // Round-robin pick: a lone requester always wins, a tie goes to prio.
  always_comb begin
    win_nxt = 1'b0;
    if (req == 2'b11) begin
      win_nxt = prio;
    end else begin
      win_nxt = req[1];
    end
    op_nxt = op[win_nxt];
  end

  // Single sequencer FSM. s and r are loaded as a complementary pair or
  // both cleared, so they can never be high together; the command's op is
  // captured once at the grant, so later changes on req/op do not reach it.
  // The counter is reloaded on entry to PULSE and GAP and the FSM advances
  // when it reaches 1, so it never decrements past 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      op_l  <= 1'b0;
      prio  <= 1'b0;
      gnt   <= 2'b00;
      s     <= 1'b0;
      r     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      gnt  <= 2'b00;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            op_l  <= op_nxt;
            prio  <= ~win_nxt;
            gnt   <= win_nxt ? 2'b10 : 2'b01;
            s     <= op_nxt;
            r     <= ~op_nxt;
            cnt   <= PULSE_LD;
            busy  <= 1'b1;
            state <= PULSE;
          end
        end
        PULSE: begin
          if (cnt <= 4'd1) begin
            s     <= 1'b0;
            r     <= 1'b0;
            cnt   <= GAP_LD;
            state <= GAP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        GAP: begin
          if (cnt <= 4'd1) begin
            cnt   <= 4'd0;
            state <= CHECK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CHECK: begin
          err   <= (q_fb != op_l);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          s     <= 1'b0;
          r     <= 1'b0;
          busy  <= 1'b0;
          cnt   <= 4'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_sequencer.sv
`timescale 1ns/1ps

module tb_sr_latch_sequencer;

  typedef struct packed {
    logic [1:0] gnt;
    logic       op;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] op;
  logic       q_fb;
  logic [1:0] gnt;
  logic       s, r, busy, done, err;

  // parameter-sweep instances
  logic [1:0] sw_req [2];
  logic [1:0] sw_op;
  logic [1:0] sw_gnt [2];
  logic [1:0] sw_s, sw_r, sw_busy, sw_done, sw_err;

  int vectors     = 0;
  int miscompares = 0;
  int stray       = 0;

  exp_t exp_q[$];

  // external latch model; stuck forces q to 0
  logic stuck   = 1'b0;
  logic q_model = 1'b0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (s) q_model <= 1'b1;
    else if (r) q_model <= 1'b0;
  end
  assign q_fb = stuck ? 1'b0 : q_model;

  sr_latch_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .q_fb(q_fb),
    .gnt(gnt), .s(s), .r(r), .busy(busy), .done(done), .err(err)
  );

  sr_latch_sequencer #(.PULSE_W(1), .GAP_W(3)) u_sw0 (
    .clk(clk), .rst_n(rst_n), .req(sw_req[0]), .op(sw_op), .q_fb(1'b1),
    .gnt(sw_gnt[0]), .s(sw_s[0]), .r(sw_r[0]), .busy(sw_busy[0]),
    .done(sw_done[0]), .err(sw_err[0])
  );

  sr_latch_sequencer #(.PULSE_W(15), .GAP_W(15)) u_sw1 (
    .clk(clk), .rst_n(rst_n), .req(sw_req[1]), .op(sw_op), .q_fb(1'b1),
    .gnt(sw_gnt[1]), .s(sw_s[1]), .r(sw_r[1]), .busy(sw_busy[1]),
    .done(sw_done[1]), .err(sw_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor for the default-parameter instance (PULSE_W=2, GAP_W=1)
  int   m_lat, m_sc, m_rc, m_bc;
  logic m_active = 1'b0;
  exp_t m_e;

  always @(negedge clk) begin
    chk("invariant_sr_gnt_done", 32'({s & r, &gnt, done & (|gnt)}), 32'd0);
    if (!rst_n) begin
      m_active = 1'b0;
    end else begin
      if (m_active) begin
        m_lat++;
        m_sc += int'(s);
        m_rc += int'(r);
        m_bc += int'(busy);
      end
      if (gnt != 2'b00) begin
        if (m_active || exp_q.size() == 0) begin
          stray++;
          chk("stray_gnt", 32'(gnt), 32'd0);
        end else begin
          chk("gnt", 32'(gnt), 32'(exp_q[0].gnt));
          m_active = 1'b1;
          m_lat = 0;
          m_sc  = int'(s);
          m_rc  = int'(r);
          m_bc  = int'(busy);
        end
      end
      if (done) begin
        if (!m_active) begin
          chk("stray_done", 32'(done), 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          chk("err", 32'(err), 32'(m_e.err));
          chk("s_width", m_sc, m_e.op ? 2 : 0);
          chk("r_width", m_rc, m_e.op ? 0 : 2);
          chk("latency", m_lat, 4);
          chk("busy_cycles", m_bc, 4);
          m_active = 1'b0;
        end
      end
    end
  end

  task automatic wait_gnts(input int n);
    int seen = 0;
    for (int i = 0; i < 300 && seen < n; i++) begin
      @(posedge clk); #1;
      if (gnt != 2'b00) seen++;
    end
    if (seen < n) chk("gnt_wait_timeout", seen, n);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic sweep(input int k, input int pw, input int gw);
    int lat = 0;
    int sc, rc, i;
    sw_req[k] = 2'b01;
    for (i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sw_gnt[k] != 2'b00) break;
    end
    chk("sweep_gnt", 32'(sw_gnt[k]), 32'd1);
    chk("sweep_busy", 32'(sw_busy[k]), 32'd1);
    sw_req[k] = 2'b00;
    sc = int'(sw_s[k]);
    rc = int'(sw_r[k]);
    while (!sw_done[k] && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      sc += int'(sw_s[k]);
      rc += int'(sw_r[k]);
    end
    chk("sweep_latency", lat, pw + gw + 1);
    chk("sweep_s_width", sc, pw);
    chk("sweep_r_width", rc, 0);
    chk("sweep_err", 32'(sw_err[k]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    req = 2'b00; op = 2'b00;
    sw_req[0] = 2'b00; sw_req[1] = 2'b00; sw_op = 2'b01;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_srbd", 32'({s, r, busy, done, err}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // tie from reset: requester 0 first (clear), then 1 (set), alternating
    op = 2'b10;
    exp_q.push_back('{2'b01, 1'b0, 1'b0});
    exp_q.push_back('{2'b10, 1'b1, 1'b0});
    exp_q.push_back('{2'b01, 1'b0, 1'b0});
    exp_q.push_back('{2'b10, 1'b1, 1'b0});
    req = 2'b11;
    wait_gnts(4);
    req = 2'b00;
    wait_drain();

    // single set
    exp_q.push_back('{2'b01, 1'b1, 1'b0});
    op = 2'b01; req = 2'b01;
    wait_gnts(1);
    req = 2'b00;
    wait_drain();

    // requester 1 pulses for one cycle while busy: must be dropped
    exp_q.push_back('{2'b01, 1'b1, 1'b0});
    op = 2'b01; req = 2'b01;
    wait_gnts(1);
    req = 2'b10;
    @(posedge clk); #1;
    req = 2'b00;
    wait_drain();
    repeat (6) @(posedge clk);
    #1;

    // stuck latch: set fails, err holds, clear passes, set fails again
    stuck = 1'b1;
    exp_q.push_back('{2'b01, 1'b1, 1'b1});
    op = 2'b01; req = 2'b01;
    wait_gnts(1);
    req = 2'b00;
    wait_drain();
    repeat (4) @(posedge clk);
    #1;
    chk("err_hold", 32'(err), 32'd1);
    exp_q.push_back('{2'b01, 1'b0, 1'b0});
    op = 2'b00; req = 2'b01;
    wait_gnts(1);
    req = 2'b00;
    wait_drain();
    exp_q.push_back('{2'b01, 1'b1, 1'b1});
    op = 2'b01; req = 2'b01;
    wait_gnts(1);
    req = 2'b00;
    wait_drain();
    stuck = 1'b0;

    // reset during the second PULSE cycle
    exp_q.push_back('{2'b01, 1'b1, 1'b0});
    op = 2'b01; req = 2'b01;
    wait_gnts(1);
    req = 2'b00;
    @(posedge clk); #2;
    chk("s_pulse2", 32'({s, r}), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_sr", 32'({s, r}), 32'd0);
    chk("async_rst_ctl", 32'({gnt, busy, done, err}), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_no_done", 32'({done, busy, s, r}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // after release: tie again starts from requester 0
    exp_q.push_back('{2'b01, 1'b1, 1'b0});
    exp_q.push_back('{2'b10, 1'b1, 1'b0});
    op = 2'b11; req = 2'b11;
    wait_gnts(2);
    req = 2'b00;
    wait_drain();

    // parameter sweep
    sweep(0, 1, 3);
    sweep(1, 15, 15);

    chk("no_stray_gnt", stray, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
